fullsub_hs_46: RTL and testbench

- Single-bit full subtractor (a − b − cin) with a zero-latency combinational path.
- Adds a registered copy of the result and a bit-serial W-bit subtract accumulator that chains the borrow across cycles.
- Serves as the arithmetic leaf cell for serial datapaths. The combinational outputs also serve standalone truth-table use.

---
 rtl/fullsub_hs_46_pkg.sv | 16 +
 rtl/fullsub_hs_46_bit.sv | 14 +
 rtl/fullsub_hs_46.sv | 132 +++++++++++++
 tb/tb_fullsub_hs_46.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fullsub_hs_46_pkg.sv
// Shared definitions for the fullsub_hs_46 full-subtractor slice.
// fs_bit is the single source of the subtract equations.
package fullsub_hs_46_pkg;

  localparam int FS_MAX_W = 32;

  // Returns {borrow_out, difference} for a - b - cin.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic cin);
    logic d_s;
    logic b_s;
    d_s = a ^ b ^ cin;
    b_s = (~a & b) | (~(a ^ b) & cin);
    return {b_s, d_s};
  endfunction

endpackage

// File: rtl/fullsub_hs_46_bit.sv
// Purely combinational single-bit full subtractor cell.
module fullsub_bit
  import fullsub_hs_46_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borr
);

  assign {borr, diff} = fs_bit(a, b, cin);

endmodule

// File: rtl/fullsub_hs_46.sv
// Full subtractor leaf cell: combinational path, registered copy and a
// bit-serial W-bit subtract accumulator chaining the borrow across cycles.
module fullsub_hs_46
  import fullsub_hs_46_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a,
  input  logic         b,
  input  logic         cin,
  output logic         diff,
  output logic         borr,
  input  logic         in_valid,
  input  logic         serial_en,
  input  logic         first,
  output logic         diff_q,
  output logic         borr_q,
  output logic         out_valid,
  output logic [W-1:0] acc_diff,
  output logic         acc_borr,
  output logic         acc_valid
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  generate
    if ((W < 2) || (W > FS_MAX_W)) begin : g_w_check
      $error("fullsub_hs_46: W must be in 2..FS_MAX_W");
    end
  endgenerate

  logic          diff_q_r;
  logic          borr_q_r;
  logic          out_valid_r;
  logic [W-1:0]  acc_diff_r;
  logic          acc_borr_r;
  logic          acc_valid_r;
  logic [CW-1:0] cnt_r;
  logic          bflop_r;
  logic [W-1:0]  sh_r;

  logic          ser_go_s;
  logic          ser_bin_s;
  logic          ser_diff_s;
  logic          ser_borr_s;
  logic [CW-1:0] cnt_eff_s;
  logic          last_s;
  logic [W-1:0]  sh_next_s;

  fullsub_bit u_ext (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .diff (diff),
    .borr (borr)
  );

  fullsub_bit u_ser (
    .a    (a),
    .b    (b),
    .cin  (ser_bin_s),
    .diff (ser_diff_s),
    .borr (ser_borr_s)
  );

  // Serial-stage steering: first restarts the word and takes borrow from cin.
  always_comb begin
    ser_go_s  = in_valid & serial_en;
    ser_bin_s = bflop_r;
    cnt_eff_s = cnt_r;
    if (first) begin
      ser_bin_s = cin;
      cnt_eff_s = {CW{1'b0}};
    end else begin
      ser_bin_s = bflop_r;
      cnt_eff_s = cnt_r;
    end
    last_s    = (cnt_eff_s == CW'(W - 1));
    sh_next_s = {ser_diff_s, sh_r[W-1:1]};
  end

  // Registered copy of the combinational result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q_r    <= 1'b0;
      borr_q_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      diff_q_r    <= diff;
      borr_q_r    <= borr;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Serial accumulator: shift LSB-first, chain borrow, publish on the W-th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_diff_r  <= {W{1'b0}};
      acc_borr_r  <= 1'b0;
      acc_valid_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      bflop_r     <= 1'b0;
      sh_r        <= {W{1'b0}};
    end else if (ser_go_s) begin
      sh_r    <= sh_next_s;
      bflop_r <= ser_borr_s;
      if (last_s) begin
        acc_diff_r  <= sh_next_s;
        acc_borr_r  <= ser_borr_s;
        acc_valid_r <= 1'b1;
        cnt_r       <= {CW{1'b0}};
      end else begin
        acc_valid_r <= 1'b0;
        cnt_r       <= cnt_eff_s + CW'(1);
      end
    end else begin
      acc_valid_r <= 1'b0;
    end
  end

  assign diff_q    = diff_q_r;
  assign borr_q    = borr_q_r;
  assign out_valid = out_valid_r;
  assign acc_diff  = acc_diff_r;
  assign acc_borr  = acc_borr_r;
  assign acc_valid = acc_valid_r;

endmodule

// File: tb/tb_fullsub_hs_46.sv
// Scoreboard bench for fullsub_hs_46: directed vectors push expectations,
// a negedge monitor pops them whenever out_valid or acc_valid is seen.
module tb_fullsub_hs_46;

  logic       clk;
  logic       rst_n;
  logic       a, b, cin;
  logic       diff, borr;
  logic       in_valid, serial_en, first;
  logic       diff_q, borr_q, out_valid;
  logic [7:0] acc_diff;
  logic       acc_borr, acc_valid;

  int pass_cnt;
  int total_cnt;

  // Truth tables indexed by {a,b,cin}.
  logic [7:0] tt_diff;
  logic [7:0] tt_borr;

  logic [1:0] reg_q[$];
  logic [8:0] acc_q[$];

  fullsub_hs_46 #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .diff      (diff),
    .borr      (borr),
    .in_valid  (in_valid),
    .serial_en (serial_en),
    .first     (first),
    .diff_q    (diff_q),
    .borr_q    (borr_q),
    .out_valid (out_valid),
    .acc_diff  (acc_diff),
    .acc_borr  (acc_borr),
    .acc_valid (acc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (reg_q.size() == 0) check("reg_unexpected", 32'd1, 32'd0);
        else check("reg_out", {30'd0, borr_q, diff_q}, {30'd0, reg_q.pop_front()});
      end
      if (acc_valid === 1'b1) begin
        if (acc_q.size() == 0) check("acc_unexpected", 32'd1, 32'd0);
        else check("acc_out", {23'd0, acc_borr, acc_diff}, {23'd0, acc_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic ia, input logic ib, input logic ic,
                           input logic iv, input logic ise, input logic ifirst);
    logic [2:0] idx;
    idx = {ia, ib, ic};
    a = ia; b = ib; cin = ic;
    in_valid = iv; serial_en = ise; first = ifirst;
    if (iv) reg_q.push_back({tt_borr[idx], tt_diff[idx]});
    @(posedge clk);
    #1;
  endtask

  // gap: 0 none, 1 in_valid=0 idle after each bit, 2 serial_en=0 bit after each bit.
  task automatic send_word(input logic [7:0] x, input logic [7:0] y, input logic c0,
                           input logic crest, input logic f0, input int gap,
                           input logic [8:0] exp);
    acc_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      drive_bit(x[i], y[i], (i == 0) ? c0 : crest, 1'b1, 1'b1, (i == 0) ? f0 : 1'b0);
      if (gap == 1) drive_bit(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      if (gap == 2) drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    tt_diff = 8'b1001_0110;
    tt_borr = 8'b1000_1110;
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0;
    in_valid = 1'b0; serial_en = 1'b0; first = 1'b0;

    #12;
    check("rst_diff_q", {31'd0, diff_q}, 32'd0);
    check("rst_borr_q", {31'd0, borr_q}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_acc_diff", {24'd0, acc_diff}, 32'd0);
    check("rst_acc_borr", {31'd0, acc_borr}, 32'd0);
    check("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a, b, cin} = v;
      #10;
      check("tt_diff", {31'd0, diff}, {31'd0, tt_diff[v]});
      check("tt_borr", {31'd0, borr}, {31'd0, tt_borr[v]});
    end

    @(posedge clk);
    #1;
    // Registered path then hold.
    drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("reg_direct_diff_q", {31'd0, diff_q}, 32'd0);
    check("reg_direct_borr_q", {31'd0, borr_q}, 32'd1);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_diff_q", {31'd0, diff_q}, 32'd0);
    check("hold_borr_q", {31'd0, borr_q}, 32'd1);

    send_word(8'h05, 8'h03, 1'b0, 1'b0, 1'b1, 0, {1'b0, 8'h02});
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("acc_single_pulse", {31'd0, acc_valid}, 32'd0);
    send_word(8'h03, 8'h05, 1'b0, 1'b0, 1'b1, 0, {1'b1, 8'hFE});
    send_word(8'h03, 8'h05, 1'b0, 1'b1, 1'b1, 1, {1'b1, 8'hFE});
    send_word(8'h03, 8'h05, 1'b0, 1'b0, 1'b1, 2, {1'b1, 8'hFE});
    send_word(8'h05, 8'h03, 1'b1, 1'b1, 1'b1, 0, {1'b0, 8'h01});
    send_word(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 0, {1'b1, 8'hFF});

    // Restart: partial word discarded by a new first.
    drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(8'hAA, 8'h55, 1'b0, 1'b1, 1'b1, 0, {1'b0, 8'h55});
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort: reset mid-word, then a word without first relies on cleared state.
    drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_diff_q", {31'd0, diff_q}, 32'd0);
    check("abort_borr_q", {31'd0, borr_q}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_acc", {23'd0, acc_borr, acc_diff}, 32'd0);
    check("abort_acc_valid", {31'd0, acc_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h05, 8'h03, 1'b1, 1'b1, 1'b0, 0, {1'b0, 8'h02});

    in_valid = 1'b0; serial_en = 1'b0; first = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((reg_q.size() == 0) && (acc_q.size() == 0)) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    check("reg_queue_drained", reg_q.size(), 32'd0);
    check("acc_queue_drained", acc_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
